// File: rtl/float_pkg.sv
// Shared types and helpers for the sequential mini-float adder.
package float_pkg;

    localparam int unsigned DEF_EXP_W = 3;
    localparam int unsigned DEF_MAN_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        ADD,
        DONE
    } state_e;

    // Field extraction on a word of up to 32 bits; callers cast to the field width.
    function automatic logic [31:0] get_exp(input logic [31:0] word,
                                            input int unsigned man_w,
                                            input int unsigned exp_w);
        return (word >> man_w) & ((32'd1 << exp_w) - 32'd1);
    endfunction

    function automatic logic [31:0] get_man(input logic [31:0] word,
                                            input int unsigned man_w);
        return word & ((32'd1 << man_w) - 32'd1);
    endfunction

endpackage

// File: rtl/float_add_core.sv
// Combinational add stage: mantissa add, carry normalise, exponent saturate, flags.
module float_add_core #(
    parameter int unsigned EXP_W = 3,
    parameter int unsigned MAN_W = 5
) (
    input  logic [EXP_W-1:0]       e_l_i,
    input  logic [MAN_W-1:0]       m_l_i,
    input  logic [MAN_W-1:0]       m_s_i,
    input  logic                   sticky_i,
    output logic [EXP_W+MAN_W-1:0] res_c,
    output logic                   ovf_c,
    output logic                   inx_c
);

    logic [MAN_W:0]   sum;
    logic [EXP_W:0]   exp_n;
    logic [MAN_W-1:0] man_n;
    logic             sticky_n;

    always_comb begin
        sum      = {1'b0, m_l_i} + {1'b0, m_s_i};
        man_n    = sum[MAN_W-1:0];
        exp_n    = {1'b0, e_l_i};
        sticky_n = sticky_i;
        res_c    = '0;
        ovf_c    = 1'b0;
        inx_c    = 1'b0;

        if (sum[MAN_W]) begin
            man_n    = sum[MAN_W:1];
            exp_n    = exp_n + (EXP_W+1)'(1);
            sticky_n = sticky_i | sum[0];
        end

        // Exponent carried past the field: saturate to all ones.
        if (exp_n[EXP_W]) begin
            res_c = '1;
            ovf_c = 1'b1;
            inx_c = 1'b1;
        end else begin
            res_c = {exp_n[EXP_W-1:0], man_n};
            inx_c = sticky_n;
        end
    end

endmodule

// File: rtl/float_add_seq.sv
// Multi-cycle mini-float adder: one-bit-per-cycle alignment behind valid/ready handshakes.
module float_add_seq
    import float_pkg::*;
#(
    parameter int unsigned EXP_W = float_pkg::DEF_EXP_W,
    parameter int unsigned MAN_W = float_pkg::DEF_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] a_in,
    input  logic [EXP_W+MAN_W-1:0] b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] result,
    output logic                   overflow,
    output logic                   inexact
);

    localparam int unsigned W = EXP_W + MAN_W;

    state_e           state_q, state_d;
    logic [EXP_W-1:0] diff_q, diff_d;
    logic [EXP_W-1:0] e_l_q, e_l_d;
    logic [MAN_W-1:0] m_l_q, m_l_d;
    logic [MAN_W-1:0] m_s_q, m_s_d;
    logic             sticky_q, sticky_d;
    logic [W-1:0]     result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             inexact_q, inexact_d;
    logic             out_valid_q, out_valid_d;

    logic [EXP_W-1:0] e_a, e_b, ld_e_l, ld_e_s, ld_diff;
    logic [MAN_W-1:0] m_a, m_b, ld_m_l, ld_m_s;
    logic             a_is_l;

    logic [W-1:0]     core_res;
    logic             core_ovf, core_inx;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign inexact   = inexact_q;

    // Operand split and swap so L always holds the larger exponent (tie keeps A).
    always_comb begin
        e_a     = EXP_W'(get_exp(32'(a_in), MAN_W, EXP_W));
        e_b     = EXP_W'(get_exp(32'(b_in), MAN_W, EXP_W));
        m_a     = MAN_W'(get_man(32'(a_in), MAN_W));
        m_b     = MAN_W'(get_man(32'(b_in), MAN_W));
        a_is_l  = (e_a >= e_b);
        ld_e_l  = a_is_l ? e_a : e_b;
        ld_e_s  = a_is_l ? e_b : e_a;
        ld_m_l  = a_is_l ? m_a : m_b;
        ld_m_s  = a_is_l ? m_b : m_a;
        ld_diff = ld_e_l - ld_e_s;
    end

    float_add_core #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_core (
        .e_l_i    (e_l_q),
        .m_l_i    (m_l_q),
        .m_s_i    (m_s_q),
        .sticky_i (sticky_q),
        .res_c    (core_res),
        .ovf_c    (core_ovf),
        .inx_c    (core_inx)
    );

    always_comb begin
        state_d     = state_q;
        diff_d      = diff_q;
        e_l_d       = e_l_q;
        m_l_d       = m_l_q;
        m_s_d       = m_s_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        inexact_d   = inexact_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    e_l_d   = ld_e_l;
                    m_l_d   = ld_m_l;
                    state_d = ALIGN;
                    // Beyond MAN_W the whole small mantissa falls off; fold it into sticky.
                    if (32'(ld_diff) > 32'(MAN_W)) begin
                        m_s_d    = '0;
                        sticky_d = |ld_m_s;
                        diff_d   = '0;
                    end else begin
                        m_s_d    = ld_m_s;
                        sticky_d = 1'b0;
                        diff_d   = ld_diff;
                    end
                end
            end
            ALIGN: begin
                if (diff_q == '0) begin
                    state_d = ADD;
                end else begin
                    m_s_d    = m_s_q >> 1;
                    sticky_d = sticky_q | m_s_q[0];
                    diff_d   = diff_q - EXP_W'(1);
                end
            end
            ADD: begin
                result_d    = core_res;
                overflow_d  = core_ovf;
                inexact_d   = core_inx;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            diff_q      <= '0;
            e_l_q       <= '0;
            m_l_q       <= '0;
            m_s_q       <= '0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            inexact_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            diff_q      <= diff_d;
            e_l_q       <= e_l_d;
            m_l_q       <= m_l_d;
            m_s_q       <= m_s_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            inexact_q   <= inexact_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_float_add_seq.sv
// Scoreboard bench for float_add_seq: directed vectors, decoupled output monitor.
module tb_float_add_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       overflow;
    logic       inexact;

    float_add_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       ov;
        logic       inx;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor samples 2ns after the falling edge, well clear of the rising edge.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out_valid: got result %0h with empty scoreboard", result);
                end else begin
                    check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("overflow", 32'(overflow), 32'(mon_e.ov));
                check("inexact", 32'(inexact), 32'(mon_e.inx));
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit push,
                        input logic [7:0] res, input logic ov, input logic inx, input int lat);
        bit   got = 1'b0;
        exp_t e;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready never rose for a=%0h b=%0h", a, b);
            return;
        end
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = ~a;
        b_in     = ~b;
        if (push) begin
            e.res = res;
            e.ov  = ov;
            e.inx = inx;
            e.lat = lat;
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL valid_timeout: out_valid stayed 0, expected 1");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = 8'h00;
        b_in      = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({overflow, inexact}), 32'd0);
        rst = 1'b0;

        send(8'b00001000, 8'b00000011, 1'b1, 8'b00001011, 1'b0, 1'b0, 2);
        send(8'b00110001, 8'b00001100, 1'b1, 8'b00110111, 1'b0, 1'b0, 3);
        send(8'b10010010, 8'b01011111, 1'b1, 8'b10011001, 1'b0, 1'b1, 4);
        send(8'b11111110, 8'b11111000, 1'b1, 8'b11111111, 1'b1, 1'b1, 2);
        send(8'b00000001, 8'b11100001, 1'b1, 8'b11100001, 1'b0, 1'b1, 2);
        send(8'b11100001, 8'b00000001, 1'b1, 8'b11100001, 1'b0, 1'b1, 2);
        send(8'b00000000, 8'b00000000, 1'b1, 8'b00000000, 1'b0, 1'b0, 2);
        send(8'b10100000, 8'b00011111, 1'b1, 8'b10100000, 1'b0, 1'b1, 7);
        send(8'b11000011, 8'b00000100, 1'b1, 8'b11000011, 1'b0, 1'b1, 2);
        send(8'b01010000, 8'b01010000, 1'b1, 8'b01110000, 1'b0, 1'b0, 2);
        drain();

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        send(8'b00110001, 8'b00001100, 1'b1, 8'b00110111, 1'b0, 1'b0, 3);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("hold_result", 32'(result), 32'b00110111);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset during a long alignment abandons the operation.
        send(8'b10100000, 8'b00011111, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("midrst_out_valid", 32'(out_valid), 32'd0);
        end
        send(8'b10010010, 8'b01011111, 1'b1, 8'b10011001, 1'b0, 1'b1, 4);
        drain();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
